// File: rtl/pipe_add_sub.sv
// Carry-pipelined adder/subtractor with valid/ready flow control and a global stall.
// Optional feature: define SATURATE_EN to clamp overflowing results to the signed limits.
`timescale 1ns/1ps
module pipe_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SL = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic             w_stall;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  logic [WIDTH-1:0] w_a_in     [STAGES];
  logic [WIDTH-1:0] w_b_in     [STAGES];
  logic [WIDTH-1:0] w_s_in     [STAGES];
  logic             w_c_in     [STAGES];
  logic             w_v_in     [STAGES];
  logic [SL:0]      w_slice    [STAGES];
  logic [WIDTH-1:0] w_s_next   [STAGES];
  logic             w_c_next   [STAGES];
  logic [WIDTH-1:0] w_sum_final;
  logic             w_ovf;

  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_ovf;

  // Subtraction is a + ~b + 1, so cin is replaced by a forced carry of one.
  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub ? 1'b1 : cin;

  assign w_stall  = r_v[L] & ~out_ready;
  assign in_ready = ~w_stall & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_in[k] = a;
      assign w_b_in[k] = w_b_eff;
      assign w_s_in[k] = {WIDTH{1'b0}};
      assign w_c_in[k] = w_c0;
      assign w_v_in[k] = in_valid;
    end else begin : g_next
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_v_in[k] = r_v[k-1];
    end

    // Each stage fills in its own slice; the upper slices of w_s_in are still zero.
    assign w_slice[k]  = {1'b0, w_a_in[k][k*SL +: SL]}
                       + {1'b0, w_b_in[k][k*SL +: SL]}
                       + {{SL{1'b0}}, w_c_in[k]};
    assign w_s_next[k] = w_s_in[k] | (WIDTH'(w_slice[k][SL-1:0]) << (k*SL));
    assign w_c_next[k] = w_slice[k][SL];
  end

  assign w_ovf = (w_a_in[L][WIDTH-1] == w_b_in[L][WIDTH-1])
              && (w_s_next[L][WIDTH-1] != w_a_in[L][WIDTH-1]);

`ifdef SATURATE_EN
  // Clamp toward the sign shared by both effective operands.
  always_comb begin
    w_sum_final = w_s_next[L];
    if (w_ovf) begin
      if (w_a_in[L][WIDTH-1]) begin
        w_sum_final = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_sum_final = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      w_sum_final = w_s_next[L];
    end
  end
`else
  assign w_sum_final = w_s_next[L];
`endif

  // Whole pipeline advances together; data registers only load on valid slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= {WIDTH{1'b0}};
        r_b[k] <= {WIDTH{1'b0}};
        r_s[k] <= {WIDTH{1'b0}};
        r_c[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_v_in[k];
        if (w_v_in[k]) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= (k == L) ? w_sum_final : w_s_next[k];
          r_c[k] <= w_c_next[k];
        end
      end
      if (w_v_in[L]) begin
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = r_v[L];
  assign sum       = r_s[L];
  assign cout      = r_c[L];
  assign ovf       = r_ovf;

endmodule

// File: doc/pipe_add_sub.md
PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-003 Parameter STAGES, default 2, SHALL set the number of carry-pipeline stages; WIDTH SHALL be divisible by STAGES.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; used in add mode only.
REQ-011 sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry-out in add mode; no-borrow flag in subtract mode (1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Add mode SHALL compute {cout,sum} = a + b + cin.
REQ-018 Subtract mode SHALL compute a + ~b + 1, ignore cin, and report the final carry as cout.
REQ-019 ovf SHALL be 1 when the operand sign bits (b inverted in subtract mode) are equal and the result sign bit differs from them.
REQ-020 Stage k SHALL add operand bits [(k+1)*W/S-1 : k*W/S] and the registered carry from stage k-1; the operand slices of later stages SHALL be delayed to align with that carry.
REQ-021 An operand set is accepted on a cycle with in_valid=1 and in_ready=1; its result SHALL appear with out_valid=1 exactly STAGES cycles later when no stall occurs.
REQ-022 Stall SHALL equal out_valid & ~out_ready; while stalled, every pipeline register holds its value and in_ready SHALL be 0.
REQ-023 in_ready SHALL be ~stall (combinational); bubbles (in_valid=0) SHALL propagate as invalid slots.
REQ-024 sum, cout and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-026 Operand values present while in_valid=0 SHALL have no effect on outputs.

Reset
REQ-027 While rst=1, all valid bits SHALL clear and out_valid, sum, cout and ovf SHALL be 0 on the next edge.
REQ-028 Reset mid-operation SHALL discard all in-flight operations.
REQ-029 While rst=1, in_ready SHALL be 0.
REQ-030 The first acceptance SHALL be possible on the first cycle after rst deasserts.

Configuration
REQ-031 With SATURATE_EN defined, an overflowing result SHALL be replaced by 0x7FF..F (both operands positive) or 0x80..0 (both negative), with ovf still asserted and cout unchanged.
REQ-032 Without SATURATE_EN, sum SHALL be the wrapped modulo-2^WIDTH result.

Verification (WIDTH=16, STAGES=2)
REQ-033 Add 0x00FF+0x0001, cin=0 -> after 2 cycles, sum=0x0100, cout=0, ovf=0 (carry crosses the stage boundary).
REQ-034 Add 0xFFFF+0x0001, cin=1 -> sum=0x0001, cout=1, ovf=0.
REQ-035 Add 0x7FFF+0x0001 -> sum=0x8000 and ovf=1; with SATURATE_EN, sum=0x7FFF and ovf=1.
REQ-036 Sub 0x0000-0x0001, cin=1 -> sum=0xFFFF, cout=0, ovf=0; sub 0x8000-0x0001 -> ovf=1.
REQ-037 Stream 0x1111+1, 0x2222+2, 0x3333+3, 0x4444+4 back-to-back with out_ready=0 for 3 cycles after the first result -> in_ready=0 during the stall, results 0x1112, 0x2224, 0x3336, 0x4448 delivered in order with none lost.
REQ-038 Assert rst with 2 operations in flight -> out_valid=0 next cycle, no stale result afterward, and a new operation after reset gives the correct result at latency 2.
